// File: rtl/bus_pkg.sv
// bus_pkg: shared arbiter state encoding and default bus dimensions.
package bus_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
   localparam int N_REQ_DEF     = 4;
   localparam int AD_LEN_DEF    = 32;
   localparam int BUS_WIDTH_DEF = 32;
   localparam int TIMEOUT_DEF   = 255;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr with wrap-around.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = IW'(j);
            gnt[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/bus_arb.sv
// bus_arb: round-robin arbiter granting one requester at a time onto a shared
// acknowledged bus, with a wait timeout and fully registered outputs.
module bus_arb
   import bus_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int AD_LEN    = AD_LEN_DEF,
   parameter int BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*AD_LEN-1:0] ad_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic [N_REQ-1:0]        done_o,
   output logic                    err_o,
   output logic [BUS_WIDTH-1:0]    data_o,
   output logic [AD_LEN-1:0]       bus_ad_o,
   output logic                    bus_req_o,
   input  logic                    bus_ack_i,
   input  logic [BUS_WIDTH-1:0]    bus_data_i
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   arb_state_t           state, state_n;
   logic [IW-1:0]        owner, owner_n, rr_ptr, rr_ptr_n, pk_idx;
   logic [CW-1:0]        wait_cnt, wait_n;
   logic [N_REQ-1:0]     gnt_n, done_n, pk_gnt;
   logic                 err_n, bus_req_n, pk_any;
   logic [BUS_WIDTH-1:0] data_n;
   logic [AD_LEN-1:0]    bus_ad_n;
   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req (req_i),
      .ptr (rr_ptr),
      .gnt (pk_gnt),
      .idx (pk_idx),
      .any (pk_any)
   );
   always_comb begin
      state_n   = state;
      owner_n   = owner;
      rr_ptr_n  = rr_ptr;
      wait_n    = wait_cnt;
      gnt_n     = gnt_o;
      done_n    = done_o;
      err_n     = err_o;
      data_n    = data_o;
      bus_ad_n  = bus_ad_o;
      bus_req_n = bus_req_o;
      case (state)
         IDLE: if (pk_any) begin
            state_n   = BUSY;
            owner_n   = pk_idx;
            gnt_n     = pk_gnt;
            bus_ad_n  = ad_i[int'(pk_idx)*AD_LEN +: AD_LEN];
            bus_req_n = 1'b1;
            wait_n    = '0;
         end
         // an acknowledge on the final wait cycle wins over the timeout
         BUSY: if (bus_ack_i || wait_cnt == CW'(TIMEOUT - 1)) begin
            state_n   = RESP;
            done_n    = gnt_o;
            err_n     = !bus_ack_i;
            data_n    = bus_ack_i ? bus_data_i : '0;
            bus_req_n = 1'b0;
         end else begin
            wait_n = wait_cnt + 1'b1;
         end
         RESP: begin
            state_n  = IDLE;
            done_n   = '0;
            err_n    = 1'b0;
            gnt_n    = '0;
            rr_ptr_n = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            wait_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         wait_cnt  <= '0;
         gnt_o     <= '0;
         done_o    <= '0;
         err_o     <= 1'b0;
         data_o    <= '0;
         bus_ad_o  <= '0;
         bus_req_o <= 1'b0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         rr_ptr    <= rr_ptr_n;
         wait_cnt  <= wait_n;
         gnt_o     <= gnt_n;
         done_o    <= done_n;
         err_o     <= err_n;
         data_o    <= data_n;
         bus_ad_o  <= bus_ad_n;
         bus_req_o <= bus_req_n;
      end
   end
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed vector table plus hand sequences for timeout, reset and dropped-request cases.
module tb_bus_arb;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic [N-1:0]  req_i = '0;
   logic [N*AW-1:0] ad_i;
   logic          bus_ack_i = 1'b0;
   logic [DW-1:0] bus_data_i = '0;
   logic [N-1:0]  gnt_o, done_o;
   logic          err_o, bus_req_o;
   logic [DW-1:0] data_o;
   logic [AW-1:0] bus_ad_o;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [N-1:0]  req;
      logic          ack;
      logic [DW-1:0] dat;
      logic [N-1:0]  gnt;
      logic [N-1:0]  done;
      logic          err;
      logic [DW-1:0] data;
      logic          breq;
      logic [AW-1:0] bad;
   } vec_t;
   vec_t vq[$];
   bus_arb #(.N_REQ(N), .AD_LEN(AW), .BUS_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_i      (req_i),
      .ad_i       (ad_i),
      .gnt_o      (gnt_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .data_o     (data_o),
      .bus_ad_o   (bus_ad_o),
      .bus_req_o  (bus_req_o),
      .bus_ack_i  (bus_ack_i),
      .bus_data_i (bus_data_i)
   );
   assign ad_i = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
   always #5 clk_i = ~clk_i;

   function automatic logic [AW-1:0] adr(input int g);
      return AW'(32'h1000 * (g + 1));
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [N-1:0] req, input logic ack, input logic [DW-1:0] dat,
                      input logic [N-1:0] gnt, input logic [N-1:0] done, input logic err,
                      input logic [DW-1:0] data, input logic breq, input logic [AW-1:0] bad);
      vec_t v;
      v = '{req, ack, dat, gnt, done, err, data, breq, bad};
      vq.push_back(v);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " gnt"}, 64'(gnt_o), 64'(0));
      chk({tag, " done"}, 64'(done_o), 64'(0));
      chk({tag, " err"}, 64'(err_o), 64'(0));
      chk({tag, " data"}, 64'(data_o), 64'(0));
      chk({tag, " bus_ad"}, 64'(bus_ad_o), 64'(0));
      chk({tag, " bus_req"}, 64'(bus_req_o), 64'(0));
   endtask

   initial begin
      repeat (2) tick();
      chk_zero("reset");
      reset_i = 1'b1;
      // all four requesting from a fresh pointer: grants 0,1,2,3,0
      for (int t = 0; t < 5; t++) begin
         add(4'hF, 1'b0, '0, N'(1 << (t % 4)), '0, 1'b0, '0, 1'b1, adr(t % 4));
         add(4'hF, 1'b1, 32'hA000_0000 + DW'(t), N'(1 << (t % 4)), N'(1 << (t % 4)), 1'b0,
             32'hA000_0000 + DW'(t), 1'b0, '0);
         add(4'hF, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
      end
      add(4'b0001, 1'b0, '0, 4'b0001, '0, 1'b0, '0, 1'b1, 32'h1000);
      add(4'b0001, 1'b0, '0, 4'b0001, '0, 1'b0, '0, 1'b1, 32'h1000);
      add(4'b0001, 1'b1, 32'hDEAD_BEEF, 4'b0001, 4'b0001, 1'b0, 32'hDEAD_BEEF, 1'b0, '0);
      add(4'b0000, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
      add(4'b0000, 1'b1, 32'h5555_5555, '0, '0, 1'b0, '0, 1'b0, '0);
      foreach (vq[i]) begin
         req_i      = vq[i].req;
         bus_ack_i  = vq[i].ack;
         bus_data_i = vq[i].dat;
         tick();
         chk($sformatf("v%0d gnt", i), 64'(gnt_o), 64'(vq[i].gnt));
         chk($sformatf("v%0d done", i), 64'(done_o), 64'(vq[i].done));
         chk($sformatf("v%0d bus_req", i), 64'(bus_req_o), 64'(vq[i].breq));
         if (vq[i].breq) chk($sformatf("v%0d bus_ad", i), 64'(bus_ad_o), 64'(vq[i].bad));
         if (vq[i].done != '0) begin
            chk($sformatf("v%0d err", i), 64'(err_o), 64'(vq[i].err));
            chk($sformatf("v%0d data", i), 64'(data_o), 64'(vq[i].data));
         end
      end
      // timeout: bus_req high for 4 cycles, error completion in the 5th
      req_i = 4'b0100;
      bus_ack_i = 1'b0;
      bus_data_i = 32'h7777_7777;
      tick();
      chk("to gnt", 64'(gnt_o), 64'(4'b0100));
      chk("to bus_req", 64'(bus_req_o), 64'(1));
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("to%0d done", k), 64'(done_o), 64'(k == 4 ? 4'b0100 : 4'b0000));
         chk($sformatf("to%0d bus_req", k), 64'(bus_req_o), 64'(k != 4));
      end
      chk("to err", 64'(err_o), 64'(1));
      chk("to data", 64'(data_o), 64'(0));
      req_i = '0;
      tick();
      chk("to idle done", 64'(done_o), 64'(0));
      chk("to idle gnt", 64'(gnt_o), 64'(0));
      // acknowledge on the last wait cycle beats the timeout
      req_i = 4'b0100;
      tick();
      chk("fin gnt", 64'(gnt_o), 64'(4'b0100));
      repeat (3) tick();
      chk("fin nodone", 64'(done_o), 64'(0));
      bus_ack_i = 1'b1;
      bus_data_i = 32'hCAFE_F00D;
      tick();
      chk("fin done", 64'(done_o), 64'(4'b0100));
      chk("fin err", 64'(err_o), 64'(0));
      chk("fin data", 64'(data_o), 64'(32'hCAFE_F00D));
      bus_ack_i = 1'b0;
      req_i = '0;
      tick();
      // requester 2 drops its request mid-transaction, 3 goes next
      req_i = 4'b0100;
      tick();
      chk("drop gnt", 64'(gnt_o), 64'(4'b0100));
      req_i = 4'b1000;
      tick();
      bus_ack_i = 1'b1;
      bus_data_i = 32'h1234_5678;
      tick();
      chk("drop done", 64'(done_o), 64'(4'b0100));
      chk("drop data", 64'(data_o), 64'(32'h1234_5678));
      bus_ack_i = 1'b0;
      tick();
      tick();
      chk("drop next gnt", 64'(gnt_o), 64'(4'b1000));
      chk("drop next ad", 64'(bus_ad_o), 64'(32'h4000));
      bus_ack_i = 1'b1;
      tick();
      chk("drop next done", 64'(done_o), 64'(4'b1000));
      bus_ack_i = 1'b0;
      req_i = '0;
      tick();
      // asynchronous reset in the middle of a transaction
      req_i = 4'b1000;
      tick();
      chk("rb gnt", 64'(gnt_o), 64'(4'b1000));
      tick();
      #2;
      reset_i = 1'b0;
      bus_ack_i = 1'b1;
      bus_data_i = 32'h0BAD_F00D;
      #1;
      chk_zero("async");
      req_i = 4'b0010;
      tick();
      chk("rst hold done", 64'(done_o), 64'(0));
      chk("rst hold gnt", 64'(gnt_o), 64'(0));
      reset_i = 1'b1;
      tick();
      chk("rel gnt", 64'(gnt_o), 64'(4'b0010));
      chk("rel done", 64'(done_o), 64'(0));
      chk("rel bus_req", 64'(bus_req_o), 64'(1));
      chk("rel bus_ad", 64'(bus_ad_o), 64'(32'h2000));
      tick();
      chk("rel ack done", 64'(done_o), 64'(4'b0010));
      chk("rel ack data", 64'(data_o), 64'(32'h0BAD_F00D));
      bus_ack_i = 1'b0;
      req_i = '0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
